// File: rtl/sched_pkg.sv
// Shared types and constants for the issue scheduler: register/unit ids,
// the decoded uop payload and one window entry.
package sched_pkg;

  localparam int REG_W   = 5;
  localparam int FUID_W  = 4;
  localparam int INSTR_W = 16;

  typedef logic [REG_W-1:0]  reg_id_t;
  typedef logic [FUID_W-1:0] fuid_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    reg_id_t [1:0]      readregs;
    reg_id_t            writereg;
    fuid_t              fuid;
  } uop_t;

  typedef struct packed {
    logic       valid;
    uop_t       uop;
    logic [1:0] src_wait;
  } entry_t;

  localparam reg_id_t NO_REG   = 5'd0;
  localparam fuid_t   FUID_NOP = 4'd0;

  // True when a real register id matches; id 0 never names a register.
  function automatic logic reg_match(reg_id_t a, reg_id_t b);
    return (a != NO_REG) && (a == b);
  endfunction

endpackage

// File: rtl/age_select.sv
// Age matrix over the window slots: age_q[i][j] set means slot i is older
// than slot j. Produces a one-hot grant for the oldest eligible slot.
module age_select #(
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] elig_i,
  output logic [DEPTH-1:0] grant_o
);

  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

  // A new slot becomes younger than every other slot; a freed slot ages nothing.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (free_i[i] || alloc_i[i]) begin
        age_d[i] = '0;
      end else begin
        age_d[i] = age_d[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (alloc_i[i] && (i != j)) begin
          age_d[j][i] = 1'b1;
        end else begin
          age_d[j][i] = age_d[j][i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  // The diagonal is always zero, so no j != i guard is needed here.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = elig_i[i];
      for (int j = 0; j < DEPTH; j++) begin
        grant_o[i] = grant_o[i] & ~(elig_i[j] & age_q[j][i]);
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Out-of-order issue window: scoreboarded dispatch, oldest-first single issue
// to one of NUM_FU units, writeback wakeup and halt drain.
module issue_scheduler
  import sched_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_FU = 8,
  parameter int NREGS  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [15:0]              disp_instr,
  input  logic [9:0]               disp_readregs,
  input  logic [4:0]               disp_writereg,
  input  logic [3:0]               disp_fuid,
  input  logic                     disp_halt,
  output logic [NUM_FU-1:0]        iss_valid,
  input  logic [NUM_FU-1:0]        iss_ready,
  output logic [15:0]              iss_instr,
  output logic [4:0]               iss_writereg,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_reg,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     halted
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [NREGS-1:0]   busy_q, busy_d;
  logic               halt_pending_q, halt_pending_d;
  logic               halted_q, halted_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic [DEPTH-1:0]   elig, grant, alloc_oh;
  logic               wb_hit, hazard, accept, alloc, fire, slot_found;
  logic [3:0]         sel_fuid;
  uop_t               disp_uop;

  assign wb_hit   = wb_valid && (wb_reg != NO_REG);
  assign disp_uop = {disp_instr, disp_readregs, disp_writereg, disp_fuid};

  // WAW against the scoreboard (a same-cycle writeback lifts it) and WAR
  // against any resident reader that has already captured its operand.
  always_comb begin
    hazard = (disp_writereg != NO_REG) && busy_q[disp_writereg] &&
             !(wb_hit && (wb_reg == disp_writereg));
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 2; k++) begin
        hazard = hazard | (entries_q[i].valid && !entries_q[i].src_wait[k] &&
                           reg_match(disp_writereg, entries_q[i].uop.readregs[k]));
      end
    end
  end

  assign disp_ready = !rst && (occ_q != OCC_W'(DEPTH)) && !halt_pending_q && !hazard;
  assign accept     = disp_valid && disp_ready;
  assign alloc      = accept && !disp_halt && (disp_fuid != FUID_NOP) &&
                      (int'(disp_fuid) < NUM_FU);
  assign fire       = |grant;

  always_comb begin
    alloc_oh   = '0;
    slot_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!slot_found && !entries_q[i].valid) begin
        alloc_oh[i] = alloc;
        slot_found  = 1'b1;
      end else begin
        alloc_oh[i] = 1'b0;
      end
    end
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (entries_q[i].valid && (entries_q[i].src_wait == 2'b00) &&
            (int'(entries_q[i].uop.fuid) == f)) begin
          elig[i] = iss_ready[f];
        end else begin
          elig[i] = elig[i];
        end
      end
    end
  end

  age_select #(.DEPTH(DEPTH)) u_age (
    .clk_i   (clk),
    .rst_i   (rst),
    .alloc_i (alloc_oh),
    .free_i  (grant),
    .elig_i  (elig),
    .grant_o (grant)
  );

  // Shared issue bus driven by the granted slot.
  always_comb begin
    iss_instr    = 16'd0;
    iss_writereg = NO_REG;
    sel_fuid     = FUID_NOP;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        iss_instr    = entries_q[i].uop.instr;
        iss_writereg = entries_q[i].uop.writereg;
        sel_fuid     = entries_q[i].uop.fuid;
      end else begin
        sel_fuid     = sel_fuid;
      end
    end
    for (int f = 0; f < NUM_FU; f++) begin
      iss_valid[f] = fire && (int'(sel_fuid) == f);
    end
  end

  // Dispatch's busy set is applied after the writeback clear so it wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_hit) busy_d[wb_reg] = 1'b0;
    else        busy_d = busy_d;
    if (alloc && (disp_writereg != NO_REG)) busy_d[disp_writereg] = 1'b1;
    else                                    busy_d = busy_d;
    busy_d[0] = 1'b0;

    entries_d = entries_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (wb_hit && (entries_q[i].uop.readregs[k] == wb_reg)) entries_d[i].src_wait[k] = 1'b0;
        else                                                     entries_d[i].src_wait[k] = entries_d[i].src_wait[k];
      end
      if (grant[i]) entries_d[i].valid = 1'b0;
      else          entries_d[i].valid = entries_d[i].valid;
      if (alloc_oh[i]) begin
        entries_d[i].valid = 1'b1;
        entries_d[i].uop   = disp_uop;
        for (int k = 0; k < 2; k++) begin
          entries_d[i].src_wait[k] = (disp_uop.readregs[k] != NO_REG) &&
                                     busy_q[disp_uop.readregs[k]] &&
                                     !(wb_hit && (wb_reg == disp_uop.readregs[k]));
        end
      end else begin
        entries_d[i] = entries_d[i];
      end
    end

    halt_pending_d = halt_pending_q | (accept && disp_halt);
    halted_d       = halted_q | (halt_pending_q && (occ_q == '0) && (busy_q == '0));

    case ({alloc, fire})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q      <= '0;
      busy_q         <= '0;
      halt_pending_q <= 1'b0;
      halted_q       <= 1'b0;
      occ_q          <= '0;
    end else begin
      entries_q      <= entries_d;
      busy_q         <= busy_d;
      halt_pending_q <= halt_pending_d;
      halted_q       <= halted_d;
      occ_q          <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: inputs change on the falling edge,
// outputs are compared 1 ns later, well away from the rising edge.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid, disp_ready, disp_halt;
  logic [15:0] disp_instr;
  logic [9:0]  disp_readregs;
  logic [4:0]  disp_writereg;
  logic [3:0]  disp_fuid;
  logic [7:0]  iss_valid, iss_ready;
  logic [15:0] iss_instr;
  logic [4:0]  iss_writereg;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [3:0]  occupancy;
  logic        halted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  issue_scheduler #(.DEPTH(8), .NUM_FU(8), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_instr(disp_instr),
    .disp_readregs(disp_readregs), .disp_writereg(disp_writereg),
    .disp_fuid(disp_fuid), .disp_halt(disp_halt),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_instr(iss_instr),
    .iss_writereg(iss_writereg), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .occupancy(occupancy), .halted(halted)
  );

  task automatic idle();
    disp_valid = 1'b0; disp_halt = 1'b0; disp_instr = 16'd0;
    disp_readregs = 10'd0; disp_writereg = 5'd0; disp_fuid = 4'd0;
  endtask

  task automatic offer(input logic [15:0] ins, input logic [4:0] s0,
                       input logic [4:0] wr, input logic [3:0] fu);
    disp_valid = 1'b1; disp_halt = 1'b0; disp_instr = ins;
    disp_readregs = {5'd0, s0}; disp_writereg = wr; disp_fuid = fu;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", disp_ready); end
    @(negedge clk); #1;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if (iss_valid !== 8'h00) begin errors++; $display("FAIL reset_iss: got %h want 00", iss_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    rst = 1'b0; #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b want 1", disp_ready); end
  endtask

  task automatic test_independent();
    @(negedge clk); iss_ready = 8'hFF; offer(16'h1111, 5'd0, 5'd3, 4'd1); #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL indep_ready: got %b want 1", disp_ready); end
    @(negedge clk); offer(16'h2222, 5'd0, 5'd5, 4'd3); #1;
    checks++; if (iss_valid !== 8'h02) begin errors++; $display("FAIL indep_iss1: got %h want 02", iss_valid); end
    checks++; if (iss_instr !== 16'h1111) begin errors++; $display("FAIL indep_instr1: got %h want 1111", iss_instr); end
    checks++; if (iss_writereg !== 5'd3) begin errors++; $display("FAIL indep_wr1: got %0d want 3", iss_writereg); end
    @(negedge clk); idle(); #1;
    checks++; if (iss_valid !== 8'h08) begin errors++; $display("FAIL indep_iss2: got %h want 08", iss_valid); end
    checks++; if (iss_instr !== 16'h2222) begin errors++; $display("FAIL indep_instr2: got %h want 2222", iss_instr); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL indep_occ1: got %0d want 1", occupancy); end
    @(negedge clk); wb_valid = 1'b1; wb_reg = 5'd3; #1;
    checks++; if (iss_valid !== 8'h00) begin errors++; $display("FAIL indep_iss3: got %h want 00", iss_valid); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL indep_occ0: got %0d want 0", occupancy); end
    @(negedge clk); wb_reg = 5'd5;
    @(negedge clk); wb_valid = 1'b0; wb_reg = 5'd0;
  endtask

  task automatic test_drop();
    @(negedge clk); offer(16'hD0D0, 5'd0, 5'd4, 4'd0); #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL drop_fu0_ready: got %b want 1", disp_ready); end
    @(negedge clk); offer(16'hD1D1, 5'd0, 5'd4, 4'd9); #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL drop_nobusy: got %b want 1", disp_ready); end
    @(negedge clk); idle(); #1;
    checks++; if (occupancy !== 4'd0 || iss_valid !== 8'h00) begin errors++; $display("FAIL drop_noalloc: got occ %0d iss %h want 0 00", occupancy, iss_valid); end
  endtask

  task automatic test_raw();
    @(negedge clk); iss_ready = 8'hFF; offer(16'hAAA1, 5'd0, 5'd3, 4'd4);
    @(negedge clk); offer(16'hBBB1, 5'd3, 5'd0, 4'd1); #1;
    checks++; if (iss_valid !== 8'h10) begin errors++; $display("FAIL raw_writer: got %h want 10", iss_valid); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle(); #1;
      checks++; if (iss_valid !== 8'h00) begin errors++; $display("FAIL raw_hold: got %h want 00", iss_valid); end
    end
    @(negedge clk); wb_valid = 1'b1; wb_reg = 5'd3; #1;
    checks++; if (iss_valid !== 8'h00) begin errors++; $display("FAIL raw_wb_cycle: got %h want 00", iss_valid); end
    @(negedge clk); wb_valid = 1'b0; wb_reg = 5'd0; #1;
    checks++; if (iss_valid !== 8'h02 || iss_instr !== 16'hBBB1) begin errors++; $display("FAIL raw_wake: got %h/%h want 02/bbb1", iss_valid, iss_instr); end
    @(negedge clk); disp_writereg = 5'd3; #1;
    checks++; if (disp_ready !== 1'b1 || occupancy !== 4'd0) begin errors++; $display("FAIL raw_busy_clear: got rdy %b occ %0d want 1 0", disp_ready, occupancy); end
    idle();
  endtask

  task automatic test_waw_war();
    @(negedge clk); iss_ready = 8'hFF; offer(16'hC701, 5'd0, 5'd7, 4'd2);
    @(negedge clk); idle();
    @(negedge clk); offer(16'hC702, 5'd0, 5'd7, 4'd1); #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL waw_stall1: got %b want 0", disp_ready); end
    @(negedge clk); #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL waw_stall2: got %b want 0", disp_ready); end
    @(negedge clk); wb_valid = 1'b1; wb_reg = 5'd7; #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL waw_wb_bypass: got %b want 1", disp_ready); end
    @(negedge clk); wb_valid = 1'b0; wb_reg = 5'd0; idle(); #1;
    checks++; if (iss_valid !== 8'h02 || iss_instr !== 16'hC702) begin errors++; $display("FAIL waw_issue: got %h/%h want 02/c702", iss_valid, iss_instr); end
    @(negedge clk); offer(16'hC703, 5'd0, 5'd7, 4'd1); #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL waw_dispatch_wins: got %b want 0", disp_ready); end
    @(negedge clk); idle(); wb_valid = 1'b1; wb_reg = 5'd7;
    @(negedge clk); wb_valid = 1'b0; wb_reg = 5'd0;
    @(negedge clk); iss_ready = 8'hF7; offer(16'h9001, 5'd9, 5'd0, 4'd3);
    @(negedge clk); offer(16'h9002, 5'd0, 5'd9, 4'd1); #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL war_stall1: got %b want 0", disp_ready); end
    @(negedge clk); #1;
    checks++; if (disp_ready !== 1'b0 || iss_valid !== 8'h00) begin errors++; $display("FAIL war_stall2: got rdy %b iss %h want 0 00", disp_ready, iss_valid); end
    @(negedge clk); iss_ready = 8'hFF;
    @(negedge clk); #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL war_release: got %b want 1", disp_ready); end
    @(negedge clk); idle(); #1;
    checks++; if (iss_valid !== 8'h02 || iss_instr !== 16'h9002) begin errors++; $display("FAIL war_issue: got %h/%h want 02/9002", iss_valid, iss_instr); end
    @(negedge clk); wb_valid = 1'b1; wb_reg = 5'd9;
    @(negedge clk); wb_valid = 1'b0; wb_reg = 5'd0;
  endtask

  // B lands in a lower slot than the older A, so index order != age order.
  task automatic test_oldest();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0A01; exp_seq[1] = 16'h0B01; exp_seq[2] = 16'h0C01;
    @(negedge clk); iss_ready = 8'hFD; offer(16'h0E00, 5'd0, 5'd0, 4'd2);
    @(negedge clk); offer(16'h0A01, 5'd0, 5'd0, 4'd1); #1;
    checks++; if (iss_valid !== 8'h04 || iss_instr !== 16'h0E00) begin errors++; $display("FAIL old_first: got %h/%h want 04/0e00", iss_valid, iss_instr); end
    @(negedge clk); offer(16'h0B01, 5'd0, 5'd0, 4'd1);
    @(negedge clk); offer(16'h0C01, 5'd0, 5'd0, 4'd1);
    @(negedge clk); offer(16'h0D02, 5'd0, 5'd0, 4'd2); #1;
    checks++; if (iss_valid !== 8'h00) begin errors++; $display("FAIL old_blocked: got %h want 00", iss_valid); end
    @(negedge clk); idle(); #1;
    checks++; if (iss_valid !== 8'h04 || iss_instr !== 16'h0D02) begin errors++; $display("FAIL old_fu2_bypass: got %h/%h want 04/0d02", iss_valid, iss_instr); end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); iss_ready = 8'hFF; #1;
      checks++; if (iss_valid !== 8'h02 || iss_instr !== exp_seq[n]) begin errors++; $display("FAIL old_order%0d: got %h/%h want 02/%h", n, iss_valid, iss_instr, exp_seq[n]); end
    end
    @(negedge clk); #1;
    checks++; if (iss_valid !== 8'h00 || occupancy !== 4'd0) begin errors++; $display("FAIL old_empty: got %h occ %0d want 00 0", iss_valid, occupancy); end
  endtask

  task automatic test_full();
    int          n_acc;
    logic [15:0] exp_i;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); iss_ready = 8'h00; offer(16'h3000 + 16'(n_acc), 5'd0, 5'd0, 4'd1); #1;
      checks++; if (disp_ready !== (i < 8)) begin errors++; $display("FAIL full_accept%0d: got %b want %b", i, disp_ready, (i < 8)); end
      if (disp_ready) n_acc++;
    end
    @(negedge clk); #1;
    checks++; if (occupancy !== 4'd8 || disp_ready !== 1'b0) begin errors++; $display("FAIL full_occ8: got occ %0d rdy %b want 8 0", occupancy, disp_ready); end
    @(negedge clk); iss_ready = 8'h02; #1;
    checks++; if (iss_valid !== 8'h02 || iss_instr !== 16'h3000 || disp_ready !== 1'b0) begin errors++; $display("FAIL full_issue: got %h/%h rdy %b want 02/3000 0", iss_valid, iss_instr, disp_ready); end
    @(negedge clk); iss_ready = 8'h00; #1;
    checks++; if (disp_ready !== 1'b1 || occupancy !== 4'd7) begin errors++; $display("FAIL full_refill: got rdy %b occ %0d want 1 7", disp_ready, occupancy); end
    @(negedge clk); offer(16'h3009, 5'd0, 5'd0, 4'd1); #1;
    checks++; if (disp_ready !== 1'b0 || occupancy !== 4'd8) begin errors++; $display("FAIL full_one_only: got rdy %b occ %0d want 0 8", disp_ready, occupancy); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); idle(); iss_ready = 8'hFF; exp_i = 16'h3000 + 16'(k); #1;
      checks++; if (iss_valid !== 8'h02 || iss_instr !== exp_i) begin errors++; $display("FAIL full_drain%0d: got %h/%h want 02/%h", k, iss_valid, iss_instr, exp_i); end
    end
    @(negedge clk); #1;
    checks++; if (occupancy !== 4'd0 || iss_valid !== 8'h00) begin errors++; $display("FAIL full_drained: got occ %0d iss %h want 0 00", occupancy, iss_valid); end
  endtask

  task automatic test_halt_reset();
    @(negedge clk); iss_ready = 8'hFF; offer(16'h4003, 5'd0, 5'd3, 4'd1);
    @(negedge clk); offer(16'hFFFF, 5'd0, 5'd0, 4'd0); disp_halt = 1'b1; #1;
    checks++; if (disp_ready !== 1'b1 || iss_valid !== 8'h02) begin errors++; $display("FAIL halt_accept: got rdy %b iss %h want 1 02", disp_ready, iss_valid); end
    @(negedge clk); offer(16'h4004, 5'd0, 5'd0, 4'd2); #1;
    checks++; if (disp_ready !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL halt_pending: got rdy %b halted %b want 0 0", disp_ready, halted); end
    @(negedge clk); idle(); wb_valid = 1'b1; wb_reg = 5'd3; #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_busy: got %b want 0", halted); end
    @(negedge clk); wb_valid = 1'b0; wb_reg = 5'd0; #1;
    checks++; if (halted !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL halt_not_yet: got %b occ %0d want 0 0", halted, occupancy); end
    @(negedge clk); #1;
    checks++; if (halted !== 1'b1 || disp_ready !== 1'b0) begin errors++; $display("FAIL halt_rise: got %b rdy %b want 1 0", halted, disp_ready); end
    @(negedge clk); #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b want 1", halted); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (occupancy !== 4'd0 || iss_valid !== 8'h00 || halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got occ %0d iss %h halted %b want 0 00 0", occupancy, iss_valid, halted); end
    rst = 1'b0; #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL halt_reset_ready: got %b want 1", disp_ready); end
    @(negedge clk); iss_ready = 8'h00; offer(16'h5001, 5'd0, 5'd6, 4'd1);
    @(negedge clk); offer(16'h5002, 5'd0, 5'd0, 4'd2);
    @(negedge clk); offer(16'h5003, 5'd0, 5'd0, 4'd1); rst = 1'b1; iss_ready = 8'hFF;
    @(negedge clk); idle(); #1;
    checks++; if (occupancy !== 4'd0 || iss_valid !== 8'h00 || halted !== 1'b0) begin errors++; $display("FAIL mid_reset: got occ %0d iss %h halted %b want 0 00 0", occupancy, iss_valid, halted); end
    rst = 1'b0;
    @(negedge clk); disp_writereg = 5'd6; #1;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_busy: got %b want 1", disp_ready); end
    idle();
  endtask

  initial begin
    rst = 1'b1; idle(); iss_ready = 8'h00; wb_valid = 1'b0; wb_reg = 5'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_independent();
    test_drop();
    test_raw();
    test_waw_war();
    test_oldest();
    test_full();
    test_halt_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Sits between the instruction decoder and the functional units.
- Accepts decoded uops (source/dest register ids, fuid, halt flag) into a DEPTH-entry window and tracks register hazards with a scoreboard.
- Issues at most one ready uop per cycle, oldest first, to the unit named by its fuid, using a valid/ready handshake.
- Writeback from the units clears scoreboard bits; a halt uop drains the machine.

Parameters:
DEPTH, 8, window entries (power of 2, >=2)
NUM_FU, 8, number of functional-unit issue ports (fuid 0..NUM_FU-1)
NREGS, 32, register-id space (5-bit ids; id 0 = "no register")

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
disp_valid  in  1  decoded uop offered
disp_ready  out  1  uop accepted this cycle when disp_valid && disp_ready
disp_instr  in  16  raw instruction, carried as payload
disp_readregs  in  2x5  source register ids (0 = unused)
disp_writereg  in  5  destination id (0 = none)
disp_fuid  in  4  target unit
disp_halt  in  1  halt uop
iss_valid  out  NUM_FU  one-hot or zero; bit f = uop offered to unit f
iss_ready  in  NUM_FU  unit f can take a uop
iss_instr  out  16  payload of the offered uop (shared bus)
iss_writereg  out  5  destination of the offered uop
wb_valid  in  1  a unit completed a write
wb_reg  in  5  register written (0 ignored)
occupancy  out  $clog2(DEPTH)+1  valid window entries
halted  out  1  halt reached and machine drained

Behaviour:
- Reset: rst clears all entries, the scoreboard, the age state and halt_pending/halted. Reset takes effect at the next edge regardless of traffic in flight; in-flight handshakes are discarded. From that edge: occupancy=0, iss_valid=0, halted=0. disp_ready=0 while rst is high, then 1.
- Entry contents: valid, uop payload, fuid, writereg, src_wait[1:0].
- Scoreboard: busy[NREGS-1:0]; bit 0 is never set.
- wb clear: wb_valid && wb_reg!=0 clears busy[wb_reg] and any matching src_wait bit in every entry.
- Dispatch stalls (disp_ready=0) on any of:
  - Window full.
  - halt_pending.
  - WAW: disp_writereg!=0 and busy[disp_writereg], unless cleared by wb this same cycle.
  - WAR: disp_writereg equals a source of any valid entry whose src_wait for that source is 0 and which has not yet issued.
- Dispatch accept:
  - disp_halt: sets halt_pending; nothing is allocated.
  - disp_fuid>=NUM_FU or fuid==0: accepted and dropped (no allocation, no busy set).
  - Otherwise: allocate the lowest free entry. Set src_wait[k] = (readregs[k]!=0) && busy[readregs[k]], with a same-cycle wb clear bypassing to 0. Set busy[writereg] if writereg!=0.
  - If wb and dispatch hit the same register in one cycle, dispatch's set wins.
- Eligibility: valid && src_wait==0 && iss_ready[fuid].
- Selection: the oldest eligible entry by dispatch order, tracked by an age matrix.
- Issue timing:
  - iss_valid is combinational from registered state and iss_ready.
  - Handshake completes the same cycle, since iss_valid is only raised when ready.
  - The entry is freed at that edge.
- Latency: dispatch edge to earliest issue is 1 cycle. A freed slot is usable by dispatch the next cycle; no same-cycle free-and-allocate.
- One issue per cycle, even when several units are ready.
- Units may deassert iss_ready arbitrarily; an offered uop need not be held, and selection re-evaluates every cycle.
- Halt: halted rises the cycle after halt_pending && occupancy==0 && busy==0. It stays high until rst.
- occupancy = count of valid entries, registered.

Decomposition:
- sched_pkg holds:
  - reg_id_t (5b), fuid_t (4b).
  - uop_t struct {instr, readregs[2], writereg, fuid}.
  - entry_t struct {valid, uop, src_wait[2]}.
  - Constants NO_REG=0, FUID_NOP=0.
- Sub-module age_select (DEPTH): age-matrix update on alloc/free, plus oldest-of-eligible one-hot output.

Test Plan:
- Independent ops: dispatch r3<-fu1 then r5<-fu3, all iss_ready=1. Expected: iss_valid=0x02 the cycle after the first, then 0x08; occupancy returns to 0.
- RAW: dispatch writer r3 (fu4), then reader of r3 (fu1); hold wb. Expected: reader never issues. Pulse wb_reg=3; reader issues the next cycle. busy[3]=0 afterwards.
- WAW/WAR stall: r7 busy, offer another writer to r7. Expected: disp_ready=0 until wb_reg=7. Also, with a waiting reader of r9 in the window, a writer to r9 sees disp_ready=0 until the reader issues.
- Oldest-first/back-pressure: three fu1 uops plus one fu2 uop; iss_ready[1]=0 for 5 cycles. Expected: fu2 uop issues first; fu1 uops then issue in dispatch order, one per cycle.
- Full window: DEPTH=8, iss_ready=0, offer 10 uops. Expected: 8 accepted, disp_ready=0, occupancy=8. After one issue, exactly one more is accepted the following cycle.
- Halt and reset: dispatch fu1 writer r3, then halt. Expected: disp_ready=0, and halted=1 one cycle after wb_reg=3 and window empty. Asserting rst mid-stream gives occupancy=0, iss_valid=0, halted=0 at the next edge.
